mem_multiport_arb: RTL and testbench

//  Parametrised N-port shared RAM: NUM_PORTS requesters share one single-ported

---
 rtl/mem_multiport_arb_if.sv | 29 ++
 rtl/mem_multiport_arb.sv | 123 ++++++++++++
 tb/tb_mem_multiport_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_multiport_arb_if.sv
// Request/grant bus between NUM_PORTS requesters and the shared RAM.
// Port p fields sit at [p*W +: W] in the packed vectors.
interface mem_multiport_arb_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]            gnt;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            addr_err;
  logic                            par_err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata,
    input  addr_err, par_err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata,
    output addr_err, par_err
  );
endinterface

// File: rtl/mem_multiport_arb.sv
// N-port round-robin shared single-port RAM, registered reads.
// Define MEM_PARITY_EN to store an even-parity bit per word.
module mem_multiport_arb #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_PORTS  = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_multiport_arb_if.slave bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  logic [MW-1:0]         mem [DEPTH];
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         sel;
  logic [NUM_PORTS-1:0]  gnt;
  logic                  hit;
  int                    idx;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_rng;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [MW-1:0]         wr_word;
  logic [MW-1:0]         rd_word;

  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  addr_err_q;

  // First requester at or after rr_ptr wins; reset masks all grants.
  always_comb begin
    gnt = '0;
    sel = '0;
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!hit && bus.req[idx]) begin
        gnt[idx] = 1'b1;
        sel      = PW'(idx);
        hit      = 1'b1;
      end
    end
    if (!rst_n) begin
      gnt = '0;
      hit = 1'b0;
    end
  end

  assign bus.gnt = gnt;

  assign sel_we    = bus.we[sel];
  assign sel_addr  = bus.addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = bus.wdata[sel*DATA_WIDTH +: DATA_WIDTH];
  assign in_rng    = (32'(sel_addr) < 32'(DEPTH));
  assign mem_idx   = in_rng ? sel_addr : '0;
  assign rd_word   = mem[mem_idx];

`ifdef MEM_PARITY_EN
  assign wr_word = {^sel_wdata, sel_wdata};
`else
  assign wr_word = sel_wdata;
`endif

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (hit && sel_we && in_rng)
      mem[mem_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_q   <= '0;
      addr_err_q <= hit && !in_rng;
      if (hit) begin
        rr_ptr <= (32'(sel) == NUM_PORTS - 1)
                ? '0 : sel + 1'b1;
        if (!sel_we) begin
          rvalid_q[sel] <= 1'b1;
          rdata_q <= in_rng
                   ? rd_word[DATA_WIDTH-1:0] : '0;
        end
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      par_q <= 1'b0;
    else
      par_q <= hit && !sel_we && in_rng &&
               (rd_word[MW-1] !=
                ^rd_word[DATA_WIDTH-1:0]);
  end

  assign bus.par_err = par_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_multiport_arb.sv
// Scoreboard bench for mem_multiport_arb, 2 ports, DEPTH 12.
// Expected outputs are queued per issued cycle and popped a cycle later.
module tb_mem_multiport_arb;

  localparam int DW  = 4;
  localparam int DEP = 12;
  localparam int AW  = 4;
  localparam int NP  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_multiport_arb_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)
  ) bus ();

  mem_multiport_arb #(
    .DATA_WIDTH(DW), .DEPTH(DEP),
    .ADDR_WIDTH(AW), .NUM_PORTS(NP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0] rv;
    logic [3:0] rd;
    logic       ae;
    logic       pe;
  } exp_t;

  exp_t       q[$];
  logic [3:0] mmem [16];
  int         mptr;
  logic [3:0] mrd;
  int         checks = 0;
  int         errors = 0;

  // Drive one cycle of requests and queue the outputs expected next cycle.
  task automatic issue(
    input  logic [1:0] r, w,
    input  logic [3:0] a0, a1, d0, d1,
    output logic [1:0] eg
  );
    exp_t e;
    int p;
    logic [3:0] a, d;
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
    eg = '0;
    p  = -1;
    if (r[mptr]) p = mptr;
    else if (r[1-mptr]) p = 1 - mptr;
    e.rv = '0;
    e.ae = 1'b0;
    e.pe = 1'b0;
    if (p >= 0) begin
      eg[p] = 1'b1;
      mptr  = (p + 1) % NP;
      a = (p == 1) ? a1 : a0;
      d = (p == 1) ? d1 : d0;
      e.ae = (int'(a) >= DEP);
      if (w[p]) begin
        if (int'(a) < DEP) mmem[a] = d;
      end else begin
        e.rv[p] = 1'b1;
        mrd = (int'(a) < DEP) ? mmem[a] : 4'h0;
      end
    end
    e.rd = mrd;
    q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.req   = 2'b11;
    bus.we    = 2'b00;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.gnt !== 2'b00) begin
        errors++;
        $display("FAIL rst_gnt got %b want 00", bus.gnt);
      end
      checks++;
      if (bus.rvalid !== 2'b00) begin
        errors++;
        $display("FAIL rst_rvalid got %b want 00", bus.rvalid);
      end
      checks++;
      if (bus.rdata !== 4'h0) begin
        errors++;
        $display("FAIL rst_rdata got %h want 0", bus.rdata);
      end
      checks++;
      if (bus.addr_err !== 1'b0 || bus.par_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_err got %b%b want 00",
                 bus.addr_err, bus.par_err);
      end
    end
    rst_n = 1'b1;
    mptr  = 0;
    mrd   = 4'h0;
    q.delete();
  endtask

  task automatic test_round_robin;
    logic [1:0] seq [4];
    logic [1:0] eg;
    exp_t e;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 2'b11, 4'd0, 4'd1,
            4'(i), 4'(8 + i), eg);
      #1;
      checks++;
      if (bus.gnt !== seq[i] || bus.gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt cyc %0d got %b want %b",
                 i, bus.gnt, seq[i]);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.addr_err !== e.ae) begin
        errors++;
        $display("FAIL rr_out cyc %0d got rv %b ae %b want rv %b ae %b",
                 i, bus.rvalid, bus.addr_err, e.rv, e.ae);
      end
    end
  endtask

  task automatic test_write_read;
    logic [1:0]  eg;
    exp_t        e;
    logic [1:0]  rq [3];
    logic [1:0]  wq [3];
    logic [3:0]  a0 [3];
    logic [3:0]  a1 [3];
    rq = '{2'b01, 2'b10, 2'b00};
    wq = '{2'b01, 2'b00, 2'b00};
    a0 = '{4'd5, 4'd0, 4'd0};
    a1 = '{4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 3; i++) begin
      issue(rq[i], wq[i], a0[i], a1[i], 4'hA, 4'h0, eg);
      #1;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL wr_gnt cyc %0d got %b want %b",
                 i, bus.gnt, eg);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.rdata !== e.rd ||
          bus.addr_err !== e.ae || bus.par_err !== e.pe) begin
        errors++;
        $display("FAIL wr_out cyc %0d got %b/%h/%b want %b/%h/%b",
                 i, bus.rvalid, bus.rdata, bus.addr_err,
                 e.rv, e.rd, e.ae);
      end
    end
  endtask

  task automatic test_addr_err;
    logic [1:0] eg;
    exp_t       e;
    logic [1:0] rq [5];
    logic [1:0] wq [5];
    logic [3:0] ad [5];
    logic [3:0] dd [5];
    rq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    wq = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    ad = '{4'd13, 4'd13, 4'd1, 4'd11, 4'd11};
    dd = '{4'h3, 4'h0, 4'h0, 4'hC, 4'h0};
    for (int i = 0; i < 5; i++) begin
      issue(rq[i], wq[i], ad[i], ad[i], dd[i], dd[i], eg);
      #1;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL ae_gnt cyc %0d got %b want %b",
                 i, bus.gnt, eg);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.rdata !== e.rd ||
          bus.addr_err !== e.ae || bus.par_err !== e.pe) begin
        errors++;
        $display("FAIL ae_out cyc %0d got %b/%h/%b want %b/%h/%b",
                 i, bus.rvalid, bus.rdata, bus.addr_err,
                 e.rv, e.rd, e.ae);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] eg;
    exp_t       e;
    logic [1:0] rq [5];
    logic [1:0] wq [5];
    logic [3:0] a0 [5];
    logic [3:0] a1 [5];
    logic [3:0] d0 [5];
    rq = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    wq = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    a0 = '{4'd7, 4'd0, 4'd3, 4'd3, 4'd0};
    a1 = '{4'd0, 4'd7, 4'd3, 4'd3, 4'd0};
    d0 = '{4'h9, 4'h0, 4'h5, 4'h5, 4'h0};
    for (int i = 0; i < 5; i++) begin
      issue(rq[i], wq[i], a0[i], a1[i], d0[i], 4'h0, eg);
      #1;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL b2b_gnt cyc %0d got %b want %b",
                 i, bus.gnt, eg);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.rdata !== e.rd ||
          bus.addr_err !== e.ae || bus.par_err !== e.pe) begin
        errors++;
        $display("FAIL b2b_out cyc %0d got %b/%h/%b want %b/%h/%b",
                 i, bus.rvalid, bus.rdata, bus.addr_err,
                 e.rv, e.rd, e.ae);
      end
    end
  endtask

  task automatic test_parity;
    logic [1:0] eg;
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        issue(2'b01, 2'b01, 4'd2, 4'd0, 4'h6, 4'h0, eg);
      end else begin
`ifdef MEM_PARITY_EN
        dut.mem[2][0] = ~dut.mem[2][0];
        mmem[2] = 4'h7;
`endif
        issue(2'b01, 2'b00, 4'd2, 4'd0, 4'h0, 4'h0, eg);
`ifdef MEM_PARITY_EN
        q[q.size()-1].pe = 1'b1;
`endif
      end
      #1;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL par_gnt cyc %0d got %b want %b",
                 i, bus.gnt, eg);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.rdata !== e.rd ||
          bus.par_err !== e.pe) begin
        errors++;
        $display("FAIL par_out cyc %0d got %b/%h/%b want %b/%h/%b",
                 i, bus.rvalid, bus.rdata, bus.par_err,
                 e.rv, e.rd, e.pe);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] eg;
    exp_t       e;
    issue(2'b01, 2'b00, 4'd5, 4'd0, 4'h0, 4'h0, eg);
    #1;
    checks++;
    if (bus.gnt !== eg) begin
      errors++;
      $display("FAIL mid_gnt got %b want %b", bus.gnt, eg);
    end
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (bus.rvalid !== e.rv || bus.rdata !== e.rd) begin
      errors++;
      $display("FAIL mid_pulse got %b/%h want %b/%h",
               bus.rvalid, bus.rdata, e.rv, e.rd);
    end
    rst_n     = 1'b0;
    bus.req   = 2'b11;
    bus.we    = 2'b10;
    bus.addr  = {4'd5, 4'd5};
    bus.wdata = {4'hF, 4'h0};
    #1;
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst_gnt got %b want 00", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rvalid !== 2'b00 || bus.rdata !== 4'h0 ||
        bus.addr_err !== 1'b0 || bus.par_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out got %b/%h/%b want 00/0/0",
               bus.rvalid, bus.rdata, bus.addr_err);
    end
    rst_n = 1'b1;
    mptr  = 0;
    mrd   = 4'h0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0)
        issue(2'b11, 2'b00, 4'd5, 4'd5, 4'h0, 4'h0, eg);
      else
        issue(2'b00, 2'b00, 4'd0, 4'd0, 4'h0, 4'h0, eg);
      #1;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL post_gnt cyc %0d got %b want %b",
                 i, bus.gnt, eg);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (bus.rvalid !== e.rv || bus.rdata !== e.rd ||
          bus.addr_err !== e.ae) begin
        errors++;
        $display("FAIL post_out cyc %0d got %b/%h/%b want %b/%h/%b",
                 i, bus.rvalid, bus.rdata, bus.addr_err,
                 e.rv, e.rd, e.ae);
      end
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mptr = 0;
    mrd  = 4'h0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_addr_err();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
